oam_dma_arbiter: RTL

//  Sits between cpu and mem_map and owns the system memory bus. Hosts the DMA register (FF46).
//  On a CPU write to FF46, copies 160 bytes from {src,8'h00} to OAM at FE00. Copy runs one byte per M-cycle.

---
 rtl/oam_dma_arbiter_pkg.sv | 26 ++
 rtl/oam_dma_arbiter_if.sv | 30 +++
 rtl/oam_dma_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/oam_dma_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gb_pkg
// Brief    : Shared types and address map for the OAM DMA bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package gb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } dma_state_t;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_BYTES    = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HIGH_PAGE    = 16'hFF00;

    // Sources in E0-FF fold back onto C0-DF (echo RAM mirror of WRAM).
    function automatic logic [7:0] echo_alias(input logic [7:0] src);
        return (src >= 8'hE0) ? (src - 8'h20) : src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_arbiter_if
// Brief    : CPU-side and mem_map-side bus bundle owned by the DMA arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface oam_dma_arbiter_if;

    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        cpu_write_in;
    logic [7:0]  cpu_data_out;
    logic [15:0] mem_addr_out;
    logic [7:0]  mem_data_out;
    logic        mem_write_out;
    logic [7:0]  mem_data_in;
    logic        dma_active_out;

    modport slave (
        input  cpu_addr_in, cpu_data_in, cpu_write_in, mem_data_in,
        output cpu_data_out, mem_addr_out, mem_data_out, mem_write_out, dma_active_out
    );

    modport master (
        output cpu_addr_in, cpu_data_in, cpu_write_in, mem_data_in,
        input  cpu_data_out, mem_addr_out, mem_data_out, mem_write_out, dma_active_out
    );

endinterface
`default_nettype wire

// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_arbiter
// Brief    : Owns the system bus; hosts FF46 and time-slices CPU vs OAM DMA.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter
    import gb_pkg::*;
#(
    parameter int MCYC_CLKS = 4
)(
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    input  wire logic        mclk_in,
    oam_dma_arbiter_if.slave bus
);

    localparam int                SLOT_W   = $clog2(MCYC_CLKS);
    localparam logic [SLOT_W-1:0] SLOT_RD  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_WR  = SLOT_W'(2);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(MCYC_CLKS - 1);
    localparam logic [7:0]        LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_t        r_state;
    logic [7:0]        r_src;
    logic [7:0]        r_idx;
    logic [7:0]        r_data;
    logic [SLOT_W-1:0] r_slot;

    logic [SLOT_W-1:0] w_slot;
    logic              w_reg_hit;
    logic              w_reg_wr;
    logic              w_high;
    logic [7:0]        w_eff_src;

    // The strobe cycle itself is slot 0; the register holds the count for the cycles after it.
    assign w_slot    = mclk_in ? '0 : r_slot;
    assign w_reg_hit = (bus.cpu_addr_in == DMA_REG_ADDR);
    assign w_reg_wr  = mclk_in & bus.cpu_write_in & w_reg_hit;
    assign w_high    = (bus.cpu_addr_in >= HIGH_PAGE);
    assign w_eff_src = echo_alias(r_src);

    assign bus.dma_active_out = (r_state == ACTIVE);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_src   <= 8'hFF;
            r_idx   <= 8'h00;
            r_data  <= 8'h00;
            r_slot  <= '0;
        end else begin
            r_slot <= (w_slot == SLOT_MAX) ? SLOT_MAX : (w_slot + SLOT_W'(1));
            if (w_reg_wr) begin
                r_src   <= bus.cpu_data_in;
                r_idx   <= 8'h00;
                r_state <= START;
            end else begin
                case (r_state)
                    IDLE: ;
                    START: begin
                        if (mclk_in) begin
                            r_state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (w_slot == SLOT_RD) begin
                            r_data <= bus.mem_data_in;
                        end
                        if (w_slot == SLOT_WR) begin
                            if (r_idx == LAST_IDX) begin
                                r_idx   <= 8'h00;
                                r_state <= IDLE;
                            end else begin
                                r_idx <= r_idx + 8'h01;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // FF46 is answered locally and never forwarded, in every state.
    always_comb begin
        bus.mem_addr_out  = bus.cpu_addr_in;
        bus.mem_data_out  = bus.cpu_data_in;
        bus.mem_write_out = bus.cpu_write_in & mclk_in & ~w_reg_hit;
        bus.cpu_data_out  = w_reg_hit ? r_src : bus.mem_data_in;
        if (r_state == ACTIVE) begin
            if (w_slot == SLOT_RD) begin
                bus.mem_addr_out  = {w_eff_src, r_idx};
                bus.mem_write_out = 1'b0;
                bus.cpu_data_out  = 8'hFF;
            end else if (w_slot == SLOT_WR) begin
                bus.mem_addr_out  = OAM_BASE + {8'h00, r_idx};
                bus.mem_data_out  = r_data;
                bus.mem_write_out = 1'b1;
                bus.cpu_data_out  = 8'hFF;
            end else if (!w_high) begin
                bus.mem_write_out = 1'b0;
                bus.cpu_data_out  = 8'hFF;
            end
        end
    end

endmodule
`default_nettype wire
